imem_fetch_unit: RTL and testbench

Instruction-memory responder that serves the fetch address driven by the decode front end and returns the 32-bit instruction word with a valid flag. It sits between the first pipeline stage (which drives `ira` and samples `ir`/`ivalid` when its pipeline allows input) and a 64-bit instruction memory port with request/grant/response handshakes. It tracks outstanding requests, buffers responses, selects the correct 32-bit half of each 64-bit beat, and discards stale responses after a redirect (jump, ecall, mret).

---
 rtl/npc_pkg.sv | 25 ++
 rtl/fetch_fifo.sv | 43 ++++
 rtl/imem_fetch_unit.sv | 93 +++++++++
 tb/tb_imem_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the fetch path: architectural widths, the nop encoding
// and the tag/response records carried through the fetch FIFOs.
package npc_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic hi;   // instruction lives in the upper half of the 64-bit beat
        logic mis;  // fetch address was not word aligned
    } fetch_tag_t;

    typedef struct packed {
        logic [ILEN-1:0] word;
        logic            fault;
    } resp_t;

    // Faulting fetches never expose memory data; they hand decode a nop.
    function automatic resp_t make_resp(input fetch_tag_t tag, input logic [XLEN-1:0] beat);
        resp_t r;
        r.fault = tag.mis;
        r.word  = tag.mis ? NOP_INST : (tag.hi ? beat[63:32] : beat[31:0]);
        return r;
    endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with occupancy count and an optional clear that
// overrides any push/pop in the same cycle. DEPTH must be a power of two.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && !clear && do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction-memory responder: credit-limited requests to a 64-bit memory port,
// in-order tag tracking, half-word selection and stale-beat dropping after redirects.
module imem_fetch_unit
    import npc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] ira,
    input  logic            fetch_req,
    input  logic            flush,
    input  logic            ir_ready,
    output logic [ILEN-1:0] ir,
    output logic            ivalid,
    output logic            ifault,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] inflight, drop_cnt, buf_count, tag_count, credits;
    fetch_tag_t    tag_in, tag_head;
    resp_t         resp_in, resp_head;
    logic          grant, rv_ok, keep_beat, consume;

    // Dropped-but-outstanding beats still hold credits until they return.
    assign credits  = DEPTH_C - (inflight + buf_count);
    assign mem_req  = rst_n & fetch_req & ~flush & (credits != '0);
    assign mem_addr = {ira[XLEN-1:3], 3'b000};
    assign grant    = mem_req & mem_gnt;

    assign rv_ok     = mem_rvalid & (inflight != '0);
    assign keep_beat = rv_ok & (drop_cnt == '0) & ~flush;
    assign consume   = ivalid & ir_ready & ~flush;

    assign tag_in.hi  = ira[2];
    assign tag_in.mis = (ira[1:0] != 2'b00);
    assign resp_in    = make_resp(tag_head, mem_rdata);

    fetch_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(DEPTH)) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (grant),
        .pop   (rv_ok),
        .clear (1'b0),
        .din   (tag_in),
        .dout  (tag_head),
        .count (tag_count)
    );

    fetch_fifo #(.WIDTH($bits(resp_t)), .DEPTH(DEPTH)) u_resp_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (keep_beat),
        .pop   (consume),
        .clear (flush),
        .din   (resp_in),
        .dout  (resp_head),
        .count (buf_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(grant) - CW'(rv_ok);
            // A beat landing in the flush cycle is already excluded here; it is dropped directly.
            if (flush)
                drop_cnt <= inflight - CW'(rv_ok);
            else if (rv_ok && drop_cnt != '0)
                drop_cnt <= drop_cnt - CW'(1);
        end
    end

    assign ivalid = rst_n & (buf_count != '0);
    assign ir     = ivalid ? resp_head.word : '0;
    assign ifault = ivalid & resp_head.fault;

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem_rvalid && inflight == '0))
                else $error("imem_fetch_unit: mem_rvalid with no request in flight");
            assert (tag_count == inflight)
                else $error("imem_fetch_unit: tag FIFO out of step with inflight count");
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Randomized scoreboard bench for imem_fetch_unit: a queue-level model of outstanding
// fetches and buffered words, with a negedge monitor comparing every cycle.
module tb_imem_fetch_unit;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n, fetch_req, flush, ir_ready, mem_gnt, mem_rvalid;
    logic [63:0] ira, mem_rdata, mem_addr;
    logic [31:0] ir;
    logic        ivalid, ifault, mem_req;

    imem_fetch_unit #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ira        (ira),
        .fetch_req  (fetch_req),
        .flush      (flush),
        .ir_ready   (ir_ready),
        .ir         (ir),
        .ivalid     (ivalid),
        .ifault     (ifault),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] a; int ep; } rec_t;
    typedef struct { logic [31:0] w; logic f; } exp_t;

    rec_t outst[$];   // granted, response not yet returned
    exp_t expq[$];    // words decode should see, in order
    int   epoch = 0;
    logic exp_req = 1'b0;
    int   n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [63:0] a, input logic [63:0] rd);
        exp_t e;
        if (a[1:0] != 2'b00) begin
            e.w = 32'h0000_0013;
            e.f = 1'b1;
        end else begin
            e.w = a[2] ? rd[63:32] : rd[31:0];
            e.f = 1'b0;
        end
        return e;
    endfunction

    // One clock of stimulus; called just after a rising edge, returns just after the next.
    task automatic cyc(input logic fr, input logic [63:0] a, input logic fl, input logic rdy,
                       input logic gnt, input logic rv, input logic [63:0] rd);
        int   credits;
        rec_t r;
        credits    = DEPTH - (outst.size() + expq.size());
        rst_n      = 1'b1;
        fetch_req  = fr;
        ira        = a;
        flush      = fl;
        ir_ready   = rdy;
        mem_gnt    = gnt;
        mem_rvalid = rv && (outst.size() != 0);
        mem_rdata  = rd;
        exp_req    = fr && !fl && (credits != 0);
        @(posedge clk);
        #1;
        if (mem_rvalid) begin
            r = outst.pop_front();
            if (!fl && r.ep == epoch) expq.push_back(mk_exp(r.a, rd));
        end
        if (fl) begin
            expq.delete();
            epoch++;
        end
        if (exp_req && gnt) outst.push_back('{a: a, ep: epoch});
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        ira        = '0;
        flush      = 1'b0;
        ir_ready   = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        exp_req    = 1'b0;
        @(posedge clk);
        #1;
        outst.delete();
        expq.delete();
        epoch++;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
    endtask

    // Monitor: compares presented outputs with the scoreboard head every cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("mem_req", {63'd0, mem_req}, {63'd0, exp_req});
            if (!rst_n) begin
                chk("rst_ivalid", {63'd0, ivalid}, 64'd0);
                chk("rst_ir", {32'd0, ir}, 64'd0);
                chk("rst_ifault", {63'd0, ifault}, 64'd0);
            end else if (expq.size() == 0) begin
                chk("ivalid_idle", {63'd0, ivalid}, 64'd0);
            end else begin
                chk("ivalid", {63'd0, ivalid}, 64'd1);
                chk("ir", {32'd0, ir}, {32'd0, expq[0].w});
                chk("ifault", {63'd0, ifault}, {63'd0, expq[0].f});
                if (ir_ready) void'(expq.pop_front());
            end
        end
    end

    initial begin
        logic [63:0] a;
        do_reset();
        chk("reset_ivalid", {63'd0, ivalid}, 64'd0);

        // Basic fetch: grant, beat next cycle, word visible the cycle after.
        cyc(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        chk("basic_addr", mem_addr, 64'h8000_0000);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0010_0093_0000_0013);
        chk("basic_ir", {32'd0, ir}, 64'h0000_0000_0010_0093);
        chk("basic_ivalid", {63'd0, ivalid}, 64'd1);
        drain();

        // Back-pressure: two fetches fill all credits, consume frees one next cycle.
        cyc(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 64'h8000_0008, 1'b0, 1'b0, 1'b1, 1'b1, 64'h1111_1111_2222_2222);
        cyc(1'b1, 64'h8000_0010, 1'b0, 1'b0, 1'b1, 1'b1, 64'h3333_3333_4444_4444);
        chk("full_req", {63'd0, mem_req}, 64'd0);
        cyc(1'b1, 64'h8000_0010, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("credit_return", {63'd0, mem_req}, 64'd1);
        drain();

        // Flush with both beats still in flight.
        cyc(1'b1, 64'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b1, 64'h8000_0004, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hdead_beef_dead_beef);
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, 64'hdead_beef_dead_beef);
        chk("flush_drop", {63'd0, ivalid}, 64'd0);
        cyc(1'b1, 64'h8000_0100, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_00a0_0513);
        chk("post_flush_ir", {32'd0, ir}, 64'h0000_0000_00a0_0513);
        drain();

        // Flush coinciding with a returning beat and a consume.
        cyc(1'b1, 64'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b1, 64'h8000_0004, 1'b0, 1'b0, 1'b1, 1'b1, 64'h5555_5555_6666_6666);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1, 64'h7777_7777_8888_8888);
        chk("flush_coincide", {63'd0, ivalid}, 64'd0);
        drain();

        // Misaligned fetch returns a faulting nop.
        cyc(1'b1, 64'h8000_0002, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 64'hffff_ffff_ffff_ffff);
        chk("mis_ifault", {63'd0, ifault}, 64'd1);
        chk("mis_ir", {32'd0, ir}, 64'h0000_0000_0000_0013);
        drain();

        // Reset with a beat in flight.
        cyc(1'b1, 64'h8000_0020, 1'b0, 1'b0, 1'b1, 1'b0, '0);
        do_reset();
        chk("mid_reset_ivalid", {63'd0, ivalid}, 64'd0);
        cyc(1'b1, 64'h8000_0040, 1'b0, 1'b1, 1'b0, 1'b0, '0);
        chk("reset_credits", {63'd0, mem_req}, 64'd1);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                a = 64'h8000_0000 + 64'({$urandom_range(0, 255), 2'b00});
                if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
                cyc($urandom_range(0, 3) != 0, a, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) != 0, {$urandom, $urandom});
            end
        end
        drain();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
